// File: rtl/eth_mac_tx.sv
// -----------------------------------------------------------------------------
// eth_mac_tx
//
// Ethernet MAC transmit framer. Takes a byte stream starting at the destination
// MAC and puts it on the wire as: preamble (0x55 x PREAMBLE_BYTES), SFD (0xD5),
// frame bytes, zero padding up to MIN_FRAME, CRC-32 FCS (LSB first), followed
// by an inter-frame gap of IFG_BYTES idle cycles. One byte per clk.
//
// Ports:
//   clk          system clock (125 MHz), rising edge
//   rst          asynchronous active-high reset
//   in_data      frame byte from upstream (first byte is DA[0])
//   in_valid     in_data valid
//   in_last      marks the final byte of the frame
//   in_ready     block accepts in_data this cycle (decoded from state only)
//   tx_data      registered byte to rgmii_tx
//   tx_valid     registered, contiguous for the whole frame
//   underrun     registered one-cycle pulse when a frame is aborted
//   frame_count  completed good frames, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module eth_mac_tx #(
  parameter int MIN_FRAME      = 60,
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        underrun,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_DROP, ST_IFG
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME);
  localparam logic [15:0] IFG_LEN  = 16'(IFG_BYTES);
  localparam logic [7:0]  PRE_LEN  = 8'(PREAMBLE_BYTES);

  // Reflected CRC-32, one byte per call.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state_reg, state_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        tx_valid_reg, tx_valid_next;
  logic        underrun_reg, underrun_next;
  logic [15:0] frame_count_reg, frame_count_next;
  logic [31:0] crc_reg, crc_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  idx_reg, idx_next;
  logic [15:0] ifg_reg, ifg_next;

  logic [16:0] cnt_inc;
  logic [15:0] cnt_sat;
  logic [31:0] crc_inv;

  // cnt_inc is the unsaturated count after this beat; it decides PAD vs FCS so
  // a saturated counter never blocks the normal end of a frame.
  assign cnt_inc = {1'b0, cnt_reg} + 17'd1;
  assign cnt_sat = (&cnt_reg) ? cnt_reg : cnt_reg + 16'd1;
  assign crc_inv = ~crc_reg;

  assign in_ready    = (state_reg == ST_SFD) || (state_reg == ST_DATA) || (state_reg == ST_DROP);
  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign underrun    = underrun_reg;
  assign frame_count = frame_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      tx_data_reg     <= 8'h00;
      tx_valid_reg    <= 1'b0;
      underrun_reg    <= 1'b0;
      frame_count_reg <= 16'h0000;
      crc_reg         <= CRC_INIT;
      cnt_reg         <= 16'h0000;
      idx_reg         <= 8'h00;
      ifg_reg         <= 16'h0000;
    end else begin
      state_reg       <= state_next;
      tx_data_reg     <= tx_data_next;
      tx_valid_reg    <= tx_valid_next;
      underrun_reg    <= underrun_next;
      frame_count_reg <= frame_count_next;
      crc_reg         <= crc_next;
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      ifg_reg         <= ifg_next;
    end
  end

  // The output registers are loaded with what the wire must show in the
  // cycle after the current one, so each state decides the next wire byte.
  always_comb begin
    state_next       = state_reg;
    tx_data_next     = tx_data_reg;
    tx_valid_next    = tx_valid_reg;
    underrun_next    = 1'b0;
    frame_count_next = frame_count_reg;
    crc_next         = crc_reg;
    cnt_next         = cnt_reg;
    idx_next         = idx_reg;
    ifg_next         = ifg_reg;

    case (state_reg)
      ST_IDLE: begin
        tx_valid_next = 1'b0;
        tx_data_next  = 8'h00;
        if (in_valid) begin
          tx_valid_next = 1'b1;
          if (PRE_LEN == 8'd0) begin
            tx_data_next = 8'hD5;
            crc_next     = CRC_INIT;
            cnt_next     = 16'h0000;
            state_next   = ST_SFD;
          end else begin
            tx_data_next = 8'h55;
            idx_next     = 8'd1;
            state_next   = ST_PREAMBLE;
          end
        end
      end

      ST_PREAMBLE: begin
        tx_valid_next = 1'b1;
        if (idx_reg < PRE_LEN) begin
          tx_data_next = 8'h55;
          idx_next     = idx_reg + 8'd1;
        end else begin
          tx_data_next = 8'hD5;
          crc_next     = CRC_INIT;
          cnt_next     = 16'h0000;
          state_next   = ST_SFD;
        end
      end

      // SFD is on the wire during ST_SFD, so the first frame byte is taken here.
      ST_SFD, ST_DATA: begin
        if (in_valid) begin
          tx_data_next  = in_data;
          tx_valid_next = 1'b1;
          crc_next      = crc_step(crc_reg, in_data);
          cnt_next      = cnt_sat;
          state_next    = ST_DATA;
          if (in_last) begin
            idx_next   = 8'd0;
            state_next = (cnt_inc < MIN_LEN) ? ST_PAD : ST_FCS;
          end
        end else begin
          tx_data_next  = 8'h00;
          tx_valid_next = 1'b0;
          underrun_next = 1'b1;
          state_next    = ST_DROP;
        end
      end

      ST_PAD: begin
        tx_data_next  = 8'h00;
        tx_valid_next = 1'b1;
        crc_next      = crc_step(crc_reg, 8'h00);
        cnt_next      = cnt_sat;
        if (cnt_inc >= MIN_LEN) begin
          idx_next   = 8'd0;
          state_next = ST_FCS;
        end
      end

      ST_FCS: begin
        tx_data_next  = crc_inv[{idx_reg[1:0], 3'b000} +: 8];
        tx_valid_next = 1'b1;
        idx_next      = idx_reg + 8'd1;
        if (idx_reg[1:0] == 2'd3) begin
          ifg_next   = IFG_LEN;
          state_next = ST_IFG;
        end
      end

      ST_DROP: begin
        tx_data_next  = 8'h00;
        tx_valid_next = 1'b0;
        if (in_valid && in_last) begin
          ifg_next   = IFG_LEN;
          state_next = ST_IFG;
        end
      end

      ST_IFG: begin
        tx_data_next  = 8'h00;
        tx_valid_next = 1'b0;
        // tx_valid still high means the last FCS byte is on the wire right
        // now: the frame completed. An aborted frame arrives with it low.
        if (tx_valid_reg) begin
          frame_count_next = frame_count_reg + 16'd1;
        end
        ifg_next = ifg_reg - 16'd1;
        if (ifg_reg <= 16'd1) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
